et_err_monitor: RTL and testbench
=================================

Name: et_err_monitor

Overview:
- Parametrised multi-channel successor of the single-pair TLK/DC error decoder.
- Each of N_CH channels captures its first error-bus strobe once per live window, and records:
  - error flag
  - lowest set bit index
  - saturating per-channel window-error count
- A window FSM closes on all-captured, timeout or live drop, and emits a one-cycle summary pulse.
- Sits in the top CDT trigger path between link/DC error collectors and trigger/run-control readout.

Parameters:
- N_CH, 2, number of error channels (channel 0 = TLK, 1 = DC by convention)
- BUS_W, 232, width of each channel's error bus
- CNT_W, 16, width of each per-channel saturating window-error counter
- TIMEOUT, 1024, cycles in ARMED before forced close; 0 disables timeout
- IDX_W, $clog2(BUS_W), derived width of first-bit index

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- in_live  in  1  live window; a window opens on a sampled 0->1 edge
- got_err  in  N_CH  per-channel strobe: bus valid this cycle
- err_bus  in  N_CH*BUS_W  concatenated error buses, channel c at [c*BUS_W +: BUS_W]
- cnt_clr  in  1  synchronous clear of all err_cnt
- is_err  out  N_CH  captured bus was nonzero
- err_done  out  N_CH  channel captured in current/last window
- first_bit  out  N_CH*IDX_W  lowest set bit index of captured bus; 0 when is_err=0
- missing  out  N_CH  channel not captured when window closed
- any_err  out  1  OR of is_err
- summary_valid  out  1  one-cycle pulse on window close
- err_cnt  out  N_CH*CNT_W  windows with is_err=1 per channel, saturating

Behaviour:
- Reset (async):
  - All outputs clear to 0.
  - FSM resets to IDLE.
  - Timer resets to 0.
  - Registered in_live copy resets to 0.
- FSM states: IDLE, ARMED, CLOSED.
- IDLE:
  - Results hold from the previous window; nothing is captured.
  - On in_live rising edge (in_live=1, registered copy 0): go to ARMED. In that same edge, clear is_err, err_done, first_bit and missing, and zero the timer.
- ARMED:
  - Timer increments each cycle.
  - Per channel c: got_err[c]=1 and err_done[c]=0 at edge t gives is_err[c], first_bit[c] and err_done[c]=1 at t+1. Latency is 1 cycle.
  - Later strobes on a done channel are ignored.
  - Strobes arriving on the opening edge are captured; the capture overrides the clear.
- Close conditions, in priority order:
  1. in_live=0
  2. all err_done (including captures made this edge)
  3. TIMEOUT!=0 and timer==TIMEOUT-1
- On close:
  - missing = ~err_done_next.
  - summary_valid pulses in the next cycle only.
  - err_cnt[c] increments for each channel with is_err_next[c]=1, saturating at 2^CNT_W-1.
  - From in_live=0 go to IDLE; otherwise go to CLOSED.
- CLOSED: no capture; go to IDLE when in_live=0. A new window needs a fresh rising edge.
- in_live drop in ARMED on the same edge as the final capture: that capture is counted and missing=0 for it.
- cnt_clr has priority over increment: on a close edge with cnt_clr=1, the counter reads 0.
- first_bit uses a pure combinational priority encoder (lowest index wins) on the bus, registered at capture.
- Async reset mid-window:
  - All state clears immediately.
  - No summary_valid pulse.
  - in_live still high after reset does not open a window until it goes low and then high again.

Optional Feature:
- Macro: ET_ERR_SYNDROME_EN.
- Defined: adds output err_syndrome (N_CH*BUS_W), the full bus latched at capture. It clears on window open and holds until the next window.
- Undefined: port and registers are absent; all other behaviour is identical.

Decomposition:
- Package et_err_pkg: FSM state enum (IDLE/ARMED/CLOSED), default N_CH/BUS_W/CNT_W/TIMEOUT constants, lowest-set-bit function.
- Sub-module et_err_chan, generated N_CH times: capture, priority encoder, done flag, saturating counter, optional syndrome.
- The top level holds the FSM, timer and close logic.

Test Plan:
- N_CH=2. in_live rises; ch0 strobe with bus bit 5 set, ch1 strobe with bus zero.
  -> is_err=2'b01, first_bit0=5, missing=0, summary_valid one pulse, err_cnt0=1, err_cnt1=0.
- TIMEOUT=8. Only ch1 strobes (bit 231 set).
  -> close 8 cycles after open, missing=2'b01, first_bit1=231, FSM goes to CLOSED until in_live falls.
- in_live drops before any strobe.
  -> missing=2'b11, is_err=0, summary_valid pulse, FSM to IDLE, results hold through IDLE.
- Repeated strobes on ch0 with changing buses.
  -> only the first is captured. A strobe on the opening edge is captured.
- CNT_W=2. Four erroring windows -> err_cnt0 saturates at 3. Assert cnt_clr on a close edge -> reads 0.
- Assert rst mid-ARMED with in_live held high.
  -> all outputs 0, no pulse, no capture until in_live toggles low then high.

Source files
------------

// File: rtl/et_err_pkg.sv
// et_err_pkg: shared FSM state type, default sizing and lowest-set-bit helper for the error monitor
package et_err_pkg;
    typedef enum logic [1:0] {IDLE, ARMED, CLOSED} state_t;
    localparam int N_CH_D = 2;
    localparam int BUS_W_D = 232;
    localparam int CNT_W_D = 16;
    localparam int TIMEOUT_D = 1024;
    localparam int LSB_MAX_W = 1024;
    // Lowest index wins; an all-zero vector yields 0.
    function automatic int lsb_idx(input logic [LSB_MAX_W-1:0] v);
        lsb_idx = 0;
        for (int i = LSB_MAX_W - 1; i >= 0; i--) if (v[i]) lsb_idx = i;
    endfunction
endpackage

// File: rtl/et_err_monitor_if.sv
// et_err_monitor_if: collector-side strobes/buses and readout results; ET_ERR_SYNDROME_EN adds err_syndrome
interface et_err_monitor_if #(
    parameter int N_CH = et_err_pkg::N_CH_D,
    parameter int BUS_W = et_err_pkg::BUS_W_D,
    parameter int CNT_W = et_err_pkg::CNT_W_D,
    parameter int IDX_W = $clog2(BUS_W)
);
    logic                    in_live;
    logic [N_CH-1:0]         got_err;
    logic [N_CH*BUS_W-1:0]   err_bus;
    logic                    cnt_clr;
    logic [N_CH-1:0]         is_err;
    logic [N_CH-1:0]         err_done;
    logic [N_CH*IDX_W-1:0]   first_bit;
    logic [N_CH-1:0]         missing;
    logic                    any_err;
    logic                    summary_valid;
    logic [N_CH*CNT_W-1:0]   err_cnt;
`ifdef ET_ERR_SYNDROME_EN
    logic [N_CH*BUS_W-1:0]   err_syndrome;
    modport master (output in_live, got_err, err_bus, cnt_clr,
                    input is_err, err_done, first_bit, missing, any_err, summary_valid, err_cnt, err_syndrome);
    modport slave (input in_live, got_err, err_bus, cnt_clr,
                   output is_err, err_done, first_bit, missing, any_err, summary_valid, err_cnt, err_syndrome);
`else
    modport master (output in_live, got_err, err_bus, cnt_clr,
                    input is_err, err_done, first_bit, missing, any_err, summary_valid, err_cnt);
    modport slave (input in_live, got_err, err_bus, cnt_clr,
                   output is_err, err_done, first_bit, missing, any_err, summary_valid, err_cnt);
`endif
endinterface

// File: rtl/et_err_chan.sv
// et_err_chan: one channel's first-strobe capture, bit encoder, done flag, saturating count; ET_ERR_SYNDROME_EN latches the bus
module et_err_chan import et_err_pkg::*; #(
    parameter int BUS_W = BUS_W_D,
    parameter int CNT_W = CNT_W_D,
    parameter int IDX_W = $clog2(BUS_W)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             open,
    input  logic             cap_en,
    input  logic             close,
    input  logic             cnt_clr,
    input  logic             got_err,
    input  logic [BUS_W-1:0] bus,
    output logic             done_next,
    output logic             is_err,
    output logic             err_done,
    output logic [IDX_W-1:0] first_bit,
    output logic             missing,
    output logic [CNT_W-1:0] err_cnt
`ifdef ET_ERR_SYNDROME_EN
    ,
    output logic [BUS_W-1:0] err_syndrome
`endif
);
    logic cap, is_err_next;
    // A strobe is taken once per window; on the opening edge the stale done flag is disregarded.
    always_comb begin
        cap = cap_en && got_err && (open || !err_done);
        done_next = err_done || cap;
        is_err_next = cap ? |bus : is_err;
    end
    // Capture overrides the window-open clear; counter clear beats the close increment.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            is_err <= 1'b0;
            err_done <= 1'b0;
            first_bit <= '0;
            missing <= 1'b0;
            err_cnt <= '0;
        end else begin
            if (cap) begin
                is_err <= |bus;
                err_done <= 1'b1;
                first_bit <= IDX_W'(lsb_idx(LSB_MAX_W'(bus)));
            end else if (open) begin
                is_err <= 1'b0;
                err_done <= 1'b0;
                first_bit <= '0;
            end
            missing <= open ? 1'b0 : close ? !done_next : missing;
            err_cnt <= cnt_clr ? '0 : (close && is_err_next && err_cnt != '1) ? err_cnt + 1'b1 : err_cnt;
        end
    end
`ifdef ET_ERR_SYNDROME_EN
    // Full bus snapshot alongside the first-bit index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) err_syndrome <= '0;
        else err_syndrome <= cap ? bus : open ? '0 : err_syndrome;
    end
`endif
endmodule

// File: rtl/et_err_monitor.sv
// et_err_monitor: window FSM, timeout and close logic over N_CH capture channels; ET_ERR_SYNDROME_EN adds err_syndrome
module et_err_monitor import et_err_pkg::*; #(
    parameter int N_CH = N_CH_D,
    parameter int BUS_W = BUS_W_D,
    parameter int CNT_W = CNT_W_D,
    parameter int TIMEOUT = TIMEOUT_D,
    parameter int IDX_W = $clog2(BUS_W)
) (
    input logic clk,
    input logic rst,
    et_err_monitor_if.slave bus
);
    localparam int TW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] T_LAST = TW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    state_t state, state_next;
    logic live_q, primed, rise, open, armed, timeout_hit, close, summary_valid;
    logic [TW-1:0] timer;
    logic [N_CH-1:0] done_next, is_err_v, err_done_v, missing_v;
    logic [N_CH*IDX_W-1:0] first_bit_v;
    logic [N_CH*CNT_W-1:0] err_cnt_v;
    // Window state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else state <= state_next;
    end
    // Live drop always returns to IDLE; a close with live still high parks in CLOSED.
    always_comb begin
        state_next = (state == IDLE) ? (rise ? ARMED : IDLE)
                   : !bus.in_live ? IDLE
                   : (state == CLOSED || close) ? CLOSED : ARMED;
    end
    // primed masks the first cycle after reset so a live level held through reset is not seen as an edge.
    always_comb begin
        rise = bus.in_live && !live_q && primed;
        open = (state == IDLE) && rise;
        armed = state == ARMED;
        timeout_hit = (TIMEOUT != 0) && (timer == T_LAST);
        close = armed && (!bus.in_live || (&done_next) || timeout_hit);
    end
    // Live edge history, window timer and the one-cycle close pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            live_q <= 1'b0;
            primed <= 1'b0;
            summary_valid <= 1'b0;
            timer <= '0;
        end else begin
            live_q <= bus.in_live;
            primed <= 1'b1;
            summary_valid <= close;
            timer <= open ? '0 : armed ? timer + 1'b1 : timer;
        end
    end
`ifdef ET_ERR_SYNDROME_EN
    logic [N_CH*BUS_W-1:0] syn_v;
    assign bus.err_syndrome = syn_v;
`endif
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        et_err_chan #(.BUS_W(BUS_W), .CNT_W(CNT_W), .IDX_W(IDX_W)) u_chan (
            .clk(clk),
            .rst(rst),
            .open(open),
            .cap_en(open || armed),
            .close(close),
            .cnt_clr(bus.cnt_clr),
            .got_err(bus.got_err[c]),
            .bus(bus.err_bus[c*BUS_W +: BUS_W]),
            .done_next(done_next[c]),
            .is_err(is_err_v[c]),
            .err_done(err_done_v[c]),
            .first_bit(first_bit_v[c*IDX_W +: IDX_W]),
            .missing(missing_v[c]),
            .err_cnt(err_cnt_v[c*CNT_W +: CNT_W])
`ifdef ET_ERR_SYNDROME_EN
            ,
            .err_syndrome(syn_v[c*BUS_W +: BUS_W])
`endif
        );
    end
    assign bus.is_err = is_err_v;
    assign bus.err_done = err_done_v;
    assign bus.first_bit = first_bit_v;
    assign bus.missing = missing_v;
    assign bus.any_err = |is_err_v;
    assign bus.summary_valid = summary_valid;
    assign bus.err_cnt = err_cnt_v;
endmodule

// File: tb/tb_et_err_monitor.sv
// tb_et_err_monitor: directed window scenarios with hand-computed results
module tb_et_err_monitor;
    import et_err_pkg::*;
    logic clk = 1'b0;
    logic rst;
    int passed = 0;
    int total = 0;
    et_err_monitor_if #(.N_CH(2), .BUS_W(232), .CNT_W(2)) ifc ();
    et_err_monitor #(.N_CH(2), .BUS_W(232), .CNT_W(2), .TIMEOUT(8)) dut (.clk(clk), .rst(rst), .bus(ifc));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic set_bus(input int b0, input int b1);
        ifc.err_bus = '0;
        if (b0 >= 0) ifc.err_bus[b0] = 1'b1;
        if (b1 >= 0) ifc.err_bus[232 + b1] = 1'b1;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        ifc.in_live = 1'b0;
        ifc.got_err = 2'b00;
        ifc.cnt_clr = 1'b0;
        set_bus(-1, -1);
        cyc();
        chk("rst_is_err", ifc.is_err, 0);
        chk("rst_done", ifc.err_done, 0);
        chk("rst_cnt", ifc.err_cnt, 0);
        chk("rst_sv", ifc.summary_valid, 0);
        chk("rst_state", dut.state, IDLE);
        rst = 1'b0;
        cyc();
        // window 1: both channels strobe, ch0 lowest bit 5, ch1 clean
        ifc.in_live = 1'b1;
        cyc();
        chk("w1_open_state", dut.state, ARMED);
        ifc.got_err = 2'b11;
        set_bus(5, -1);
        ifc.err_bus[9] = 1'b1;
        cyc();
        chk("w1_is_err", ifc.is_err, 2'b01);
        chk("w1_done", ifc.err_done, 2'b11);
        chk("w1_fb0", ifc.first_bit[7:0], 5);
        chk("w1_fb1", ifc.first_bit[15:8], 0);
        chk("w1_missing", ifc.missing, 0);
        chk("w1_sv", ifc.summary_valid, 1);
        chk("w1_cnt0", ifc.err_cnt[1:0], 1);
        chk("w1_cnt1", ifc.err_cnt[3:2], 0);
        chk("w1_any", ifc.any_err, 1);
        chk("w1_state", dut.state, CLOSED);
        ifc.got_err = 2'b01;
        set_bus(3, -1);
        cyc();
        chk("w1_sv_pulse", ifc.summary_valid, 0);
        chk("w1_closed_nocap", ifc.first_bit[7:0], 5);
        ifc.got_err = 2'b00;
        ifc.in_live = 1'b0;
        cyc();
        chk("w1_idle", dut.state, IDLE);
        chk("w1_hold", ifc.is_err, 2'b01);
        // window 2: only ch1 strobes (bit 231), timeout closes it
        ifc.in_live = 1'b1;
        cyc();
        chk("w2_clr_is_err", ifc.is_err, 0);
        chk("w2_clr_done", ifc.err_done, 0);
        chk("w2_clr_fb0", ifc.first_bit[7:0], 0);
        ifc.got_err = 2'b10;
        set_bus(-1, 231);
        cyc();
        ifc.got_err = 2'b00;
        for (int i = 0; i < 6; i++) cyc();
        chk("w2_pre_sv", ifc.summary_valid, 0);
        chk("w2_pre_state", dut.state, ARMED);
        cyc();
        chk("w2_sv", ifc.summary_valid, 1);
        chk("w2_missing", ifc.missing, 2'b01);
        chk("w2_fb1", ifc.first_bit[15:8], 231);
        chk("w2_is_err", ifc.is_err, 2'b10);
        chk("w2_cnt", ifc.err_cnt, 4'b0101);
        chk("w2_state", dut.state, CLOSED);
        cyc();
        chk("w2_sv_pulse", ifc.summary_valid, 0);
        chk("w2_stay_closed", dut.state, CLOSED);
        ifc.in_live = 1'b0;
        cyc();
        chk("w2_idle", dut.state, IDLE);
        // window 3: live drops before any strobe
        ifc.in_live = 1'b1;
        cyc();
        chk("w3_clr_missing", ifc.missing, 0);
        ifc.in_live = 1'b0;
        cyc();
        chk("w3_missing", ifc.missing, 2'b11);
        chk("w3_is_err", ifc.is_err, 0);
        chk("w3_sv", ifc.summary_valid, 1);
        chk("w3_state", dut.state, IDLE);
        chk("w3_cnt", ifc.err_cnt, 4'b0101);
        cyc();
        chk("w3_sv_pulse", ifc.summary_valid, 0);
        chk("w3_hold", ifc.missing, 2'b11);
        // window 4: strobe on the opening edge is captured, later ch0 strobes ignored
        ifc.in_live = 1'b1;
        ifc.got_err = 2'b01;
        set_bus(17, -1);
        cyc();
        chk("w4_open_cap", ifc.is_err, 2'b01);
        chk("w4_open_fb0", ifc.first_bit[7:0], 17);
        chk("w4_open_done", ifc.err_done, 2'b01);
        set_bus(2, -1);
        cyc();
        chk("w4_repeat_ign", ifc.first_bit[7:0], 17);
        chk("w4_repeat_sv", ifc.summary_valid, 0);
        ifc.got_err = 2'b10;
        set_bus(-1, -1);
        cyc();
        chk("w4_sv", ifc.summary_valid, 1);
        chk("w4_fb0", ifc.first_bit[7:0], 17);
        chk("w4_cnt", ifc.err_cnt, 4'b0110);
        ifc.got_err = 2'b00;
        ifc.in_live = 1'b0;
        cyc();
        // window 5: ch0 counter reaches 3
        ifc.in_live = 1'b1;
        ifc.got_err = 2'b11;
        set_bus(0, -1);
        cyc();
        ifc.got_err = 2'b00;
        cyc();
        chk("w5_sv", ifc.summary_valid, 1);
        chk("w5_cnt0", ifc.err_cnt[1:0], 3);
        chk("w5_fb0", ifc.first_bit[7:0], 0);
        ifc.in_live = 1'b0;
        cyc();
        // window 6: final capture lands on the live-drop edge; ch0 saturates
        ifc.in_live = 1'b1;
        ifc.got_err = 2'b01;
        set_bus(0, -1);
        cyc();
        ifc.got_err = 2'b10;
        set_bus(-1, -1);
        ifc.in_live = 1'b0;
        cyc();
        chk("w6_missing", ifc.missing, 0);
        chk("w6_state", dut.state, IDLE);
        chk("w6_sat", ifc.err_cnt, 4'b0111);
        ifc.got_err = 2'b00;
        cyc();
        // window 7: counter clear on the close edge
        ifc.in_live = 1'b1;
        ifc.got_err = 2'b11;
        set_bus(1, -1);
        cyc();
        ifc.got_err = 2'b00;
        ifc.cnt_clr = 1'b1;
        cyc();
        chk("w7_sv", ifc.summary_valid, 1);
        chk("w7_clr", ifc.err_cnt, 0);
        ifc.cnt_clr = 1'b0;
        ifc.in_live = 1'b0;
        cyc();
        // window 8: reset in the middle of an armed window
        ifc.in_live = 1'b1;
        cyc();
        ifc.got_err = 2'b01;
        set_bus(4, -1);
        cyc();
        chk("w8_cap", ifc.first_bit[7:0], 4);
        ifc.got_err = 2'b00;
        rst = 1'b1;
        #1;
        chk("w8_rst_is_err", ifc.is_err, 0);
        chk("w8_rst_fb", ifc.first_bit, 0);
        chk("w8_rst_state", dut.state, IDLE);
        cyc();
        chk("w8_rst_sv", ifc.summary_valid, 0);
        rst = 1'b0;
        ifc.got_err = 2'b11;
        set_bus(6, -1);
        cyc();
        cyc();
        chk("w8_no_open", dut.state, IDLE);
        chk("w8_no_cap", ifc.err_done, 0);
        chk("w8_no_sv", ifc.summary_valid, 0);
        ifc.got_err = 2'b00;
        ifc.in_live = 1'b0;
        cyc();
        ifc.in_live = 1'b1;
        cyc();
        chk("w8_reopen", dut.state, ARMED);
        ifc.got_err = 2'b01;
        cyc();
        chk("w8_recap", ifc.first_bit[7:0], 6);
        ifc.got_err = 2'b00;
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
